// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame defaults and FSM state encoding, common to uart_tx and uart_rx.
package uart_tx_pkg;

  localparam int UART_DEFAULT_DATA_LENGTH = 8;
  localparam int UART_DEFAULT_BAUD_COUNTS = 521;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..COUNTS_PER_BIT-1 and pulses tick_o on the last count of each period.
module uart_baud_counter
  import uart_tx_pkg::*;
#(
  parameter int COUNTS_PER_BIT = UART_DEFAULT_BAUD_COUNTS,
  parameter int COUNTER_WIDTH  = 10
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == COUNTER_WIDTH'(COUNTS_PER_BIT - 1));

  // Wrapping on tick keeps every bit period exactly COUNTS_PER_BIT clocks long.
  always_comb begin
    cnt_d = cnt_q + COUNTER_WIDTH'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, LSB-first data bits, stop bit, all outputs registered.
// Handshake: start_strb_i is a one-cycle request, accepted only while busy_o is low.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int UART_DATA_LENGTH           = UART_DEFAULT_DATA_LENGTH,
  parameter int TX_COUNTER_BITWIDTH        = 3,
  parameter int BAUD_COUNTS_PER_BIT        = UART_DEFAULT_BAUD_COUNTS,
  parameter int BAUD_RATE_COUNTER_BITWIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [UART_DATA_LENGTH-1:0] data_i,
  input  logic                        start_strb_i,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        done_strb_o
);

  uart_state_e                    state_q, state_d;
  logic [UART_DATA_LENGTH-1:0]    shift_q, shift_d, shift_shr;
  logic [TX_COUNTER_BITWIDTH-1:0] idx_q, idx_d;
  logic                           tx_q, tx_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           baud_tick;
  logic                           baud_clear;

  // Counter is held at zero while idle so the start bit gets a full period.
  assign baud_clear = (state_q == IDLE);

  uart_baud_counter #(
    .COUNTS_PER_BIT (BAUD_COUNTS_PER_BIT),
    .COUNTER_WIDTH  (BAUD_RATE_COUNTER_BITWIDTH)
  ) u_baud (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (baud_clear),
    .tick_o  (baud_tick)
  );

  assign shift_shr = shift_q >> 1;

  // Outputs are computed from the next state so tx_o/busy_o/done_strb_o come straight off flops.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_strb_i) begin
          state_d = START;
          shift_d = data_i;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_tick) begin
          shift_d = shift_shr;
          if (idx_q == TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + TX_COUNTER_BITWIDTH'(1);
            tx_d  = shift_shr[0];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_o        = tx_q;
  assign busy_o      = busy_q;
  assign done_strb_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level line model, loopback decoder, random traffic.
module tb_uart_tx;

  localparam int LEN = 8;
  localparam int B   = 4;
  localparam int FRAME_SAMPLES = (LEN + 2) * B;

  logic           clk;
  logic           reset_i;
  logic [LEN-1:0] data_i;
  logic           start_strb_i;
  logic           tx_o;
  logic           busy_o;
  logic           done_strb_o;

  int vectors;
  int miscompares;

  uart_tx #(
    .UART_DATA_LENGTH           (LEN),
    .TX_COUNTER_BITWIDTH        (3),
    .BAUD_COUNTS_PER_BIT        (B),
    .BAUD_RATE_COUNTER_BITWIDTH (3)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .data_i       (data_i),
    .start_strb_i (start_strb_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_strb_o  (done_strb_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an accepted byte becomes a list of line samples (start, data LSB-first, stop).
  logic           line_q[$];
  logic [LEN-1:0] exp_q[$];
  logic           m_tx, m_busy, m_done;
  logic           chk_en;
  int             m_frames_done;

  initial begin
    m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0; chk_en = 1'b0; m_frames_done = 0;
  end

  always @(posedge clk) begin
    if (reset_i) begin
      line_q.delete();
      exp_q.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0;
      chk_en = 1'b1;
    end else if (!m_busy) begin
      m_done = 1'b0;
      m_tx   = 1'b1;
      if (start_strb_i) begin
        exp_q.push_back(data_i);
        for (int bit_i = 0; bit_i < LEN + 2; bit_i++) begin
          for (int c = 0; c < B; c++) begin
            if (bit_i == 0)            line_q.push_back(1'b0);
            else if (bit_i == LEN + 1) line_q.push_back(1'b1);
            else                       line_q.push_back(data_i[bit_i-1]);
          end
        end
        m_tx   = line_q.pop_front();
        m_busy = 1'b1;
      end
    end else if (line_q.size() > 0) begin
      m_tx = line_q.pop_front();
    end else begin
      m_busy = 1'b0;
      m_tx   = 1'b1;
      m_done = 1'b1;
      m_frames_done++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("tx_o", tx_o, m_tx);
      check_eq("busy_o", busy_o, m_busy);
      check_eq("done_strb_o", done_strb_o, m_done);
    end
  end

  // Loopback receiver: mid-bit sampling of tx_o, compared against the bytes the model accepted.
  logic           rx_active;
  logic           rx_prev;
  int             rx_cnt;
  int             rx_frames;
  logic [LEN-1:0] rx_byte;
  logic [LEN-1:0] rx_exp;

  initial begin
    rx_active = 1'b0; rx_prev = 1'b1; rx_cnt = 0; rx_frames = 0; rx_byte = '0;
  end

  always @(negedge clk) begin
    if (reset_i || !chk_en) begin
      rx_active = 1'b0;
      rx_prev   = 1'b1;
    end else begin
      if (!rx_active) begin
        if (rx_prev && !tx_o) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_active && (rx_cnt % B == B / 2)) begin
        if (rx_cnt / B == 0) begin
          check_eq("rx_start_bit", tx_o, 1'b0);
        end else if (rx_cnt / B <= LEN) begin
          rx_byte[rx_cnt/B-1] = tx_o;
        end else begin
          check_eq("rx_stop_bit", tx_o, 1'b1);
          rx_exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx_byte;
          check_eq("rx_byte", rx_byte, rx_exp);
          rx_frames++;
          rx_active = 1'b0;
        end
      end
      rx_prev = tx_o;
    end
  end

  // driver tasks
  task automatic send(input logic [LEN-1:0] b);
    @(negedge clk);
    data_i       = b;
    start_strb_i = 1'b1;
    @(negedge clk);
    start_strb_i = 1'b0;
    data_i       = LEN'($urandom);
  endtask

  task automatic wait_idle(input int budget, input logic scramble);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      @(negedge clk);
      if (scramble) begin
        data_i       = LEN'($urandom);
        start_strb_i = ($urandom_range(0, 5) == 0);
      end
      n++;
    end
    start_strb_i = 1'b0;
    if (m_busy) check_eq("idle_timeout", 1, 0);
  endtask

  task automatic wait_done_cycle(input int budget);
    int n;
    n = 0;
    while (!m_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!m_done) check_eq("done_timeout", 1, 0);
  endtask

  initial begin
    int busy_len;
    int frames_before;
    vectors = 0; miscompares = 0;
    reset_i = 1'b1; start_strb_i = 1'b0; data_i = '0;

    // Reset held for 3 clocks, with a strobe that must be dropped
    repeat (2) @(negedge clk);
    start_strb_i = 1'b1; data_i = 8'h77;
    @(negedge clk);
    reset_i = 1'b0; start_strb_i = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame 0xA5, with a direct busy-length measurement
    send(8'hA5);
    busy_len = 1;
    while (busy_o && busy_len < 100) begin
      @(negedge clk);
      data_i = LEN'($urandom);
      if (busy_o) busy_len++;
    end
    check_eq("a5_busy_len", busy_len, FRAME_SAMPLES);
    check_eq("a5_done", done_strb_o, 1'b1);
    repeat (3) @(negedge clk);

    // Back-to-back 0x00 then 0xFF, second strobe in the done cycle
    send(8'h00);
    wait_done_cycle(100);
    data_i = 8'hFF; start_strb_i = 1'b1;
    @(negedge clk);
    start_strb_i = 1'b0;
    check_eq("b2b_start_low", tx_o, 1'b0);
    wait_idle(100, 1'b0);
    repeat (2) @(negedge clk);

    // Strobe during a frame is ignored
    frames_before = m_frames_done;
    send(8'h81);
    repeat (10) @(negedge clk);
    data_i = 8'h3C; start_strb_i = 1'b1;
    @(negedge clk);
    start_strb_i = 1'b0;
    wait_idle(100, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("ignored_strobe_frames", m_frames_done - frames_before, 1);

    // Reset mid-frame, then a clean frame
    send(8'h55);
    repeat (15) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check_eq("mid_reset_tx", tx_o, 1'b1);
    check_eq("mid_reset_busy", busy_o, 1'b0);
    @(negedge clk);
    send(8'h12);
    wait_idle(100, 1'b0);
    repeat (2) @(negedge clk);

    // Start held high: one frame per idle visit
    frames_before = m_frames_done;
    @(negedge clk);
    data_i = 8'h5A; start_strb_i = 1'b1;
    wait_done_cycle(100);
    @(negedge clk);
    wait_done_cycle(100);
    @(negedge clk);
    start_strb_i = 1'b0;
    wait_idle(100, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("held_start_frames", m_frames_done - frames_before, 3);

    // Random loopback traffic with ignored mid-frame strobes and scrambled data_i
    for (int i = 0; i < 256; i++) begin
      send(LEN'($urandom));
      wait_idle(100, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    check_eq("rx_frame_count", rx_frames, m_frames_done);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
